// File: rtl/mems_dac_spi.sv
// ----------------------------------------------------------------------------
// mems_dac_spi
//
// SPI master for the MEMS mirror DAC. It sits directly downstream of the MEMS
// scan controller. A one-cycle start pulse fetches the command word at the
// controller's current ROM address, which is a synchronous ROM. The word is then
// shifted MSB-first to the DAC. busy is registered. It rises the cycle after
// start and falls the cycle the block is back in IDLE. This timing keeps the
// controller's "!busy && !start_q" issue test from firing while a word is active.
//
// Frame timing, with start sampled in cycle T:
//   WAIT_ROM  T+1 .. T+ROM_LATENCY      rom_data is captured on the last cycle
//   SHIFT     2*CLK_DIV*WORD_BITS cycles, sync_n low; each bit is CLK_DIV
//             cycles of sclk high followed by CLK_DIV cycles of sclk low
//   GAP       GAP_CYCLES cycles, sync_n high
//   busy width = ROM_LATENCY + 2*CLK_DIV*WORD_BITS + GAP_CYCLES
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active high; aborts a word immediately
//   start     in   one-cycle request; the ROM address is valid in this cycle
//   rom_data  in   [WORD_BITS-1:0] ROM read data, ROM_LATENCY cycles after start
//   busy      out  high while a word is in progress
//   sclk      out  SPI clock; idles high; the DAC samples on the falling edge
//   mosi      out  SPI data; changes only while sclk is high
//   sync_n    out  DAC frame sync, active low
//   ldac_n    out  (MEMS_DAC_LDAC_EN builds only) low for the first two GAP
//                  cycles after each completed word; GAP_CYCLES must be >= 3
//
// Build option: define MEMS_DAC_LDAC_EN to add the ldac_n output. Without it,
// the DAC runs in self-updating mode.
// ----------------------------------------------------------------------------
module mems_dac_spi #(
  parameter int WORD_BITS   = 24,
  parameter int CLK_DIV     = 2,
  parameter int ROM_LATENCY = 1,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WORD_BITS-1:0] rom_data,
  output logic                 busy,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 sync_n
`ifdef MEMS_DAC_LDAC_EN
  ,
  output logic                 ldac_n
`endif
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(WORD_BITS) + 1;
  localparam int TMR_W = $clog2(ROM_LATENCY + GAP_CYCLES) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_FIRST = BIT_W'(WORD_BITS - 1);
  localparam logic [TMR_W-1:0] ROM_LAST  = TMR_W'(ROM_LATENCY - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ROM,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t               state;
  logic [DIV_W-1:0]     div_cnt;   // cycles spent in the current sclk phase
  logic [BIT_W-1:0]     bit_cnt;   // index of the bit on mosi, WORD_BITS-1 .. 0
  logic [TMR_W-1:0]     tmr;       // shared by the WAIT_ROM and GAP phases
  logic [WORD_BITS-1:0] shreg;

  // NOTE: every register in this block is assigned with <= only. Each
  // right-hand side therefore reads the value from before the clock edge, so the
  // order of the statements below does not change the behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register and counters are cleared along with the control
      // state. A word aborted by rst then leaves no stale data behind for the
      // next frame.
      state   <= S_IDLE;
      busy    <= 1'b0;
      sclk    <= 1'b1;
      mosi    <= 1'b0;
      sync_n  <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      tmr     <= '0;
      shreg   <= '0;
`ifdef MEMS_DAC_LDAC_EN
      ldac_n  <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_WAIT_ROM;
            busy  <= 1'b1;
            tmr   <= '0;
          end
        end

        S_WAIT_ROM: begin
          if (tmr == ROM_LAST) begin
            // The first bit goes out together with the capture. SHIFT then
            // starts with sync_n low and the MSB already on mosi.
            shreg   <= rom_data;
            mosi    <= rom_data[WORD_BITS-1];
            sync_n  <= 1'b0;
            sclk    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= BIT_FIRST;
            state   <= S_SHIFT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        S_SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (sclk) begin
              sclk <= 1'b0;
            end else if (bit_cnt == '0) begin
              // The low phase of the last bit has ended, so the frame closes.
              state  <= S_GAP;
              sclk   <= 1'b1;
              sync_n <= 1'b1;
              mosi   <= 1'b0;
              tmr    <= '0;
`ifdef MEMS_DAC_LDAC_EN
              ldac_n <= 1'b0;
`endif
            end else begin
              // sclk returns high and mosi moves to the next bit in the same
              // cycle. The data therefore never changes while sclk is low. The
              // register rotates so the current MSB always sits at the top.
              sclk    <= 1'b1;
              bit_cnt <= bit_cnt - 1'b1;
              mosi    <= shreg[WORD_BITS-2];
              shreg   <= {shreg[WORD_BITS-2:0], shreg[WORD_BITS-1]};
            end
          end
        end

        S_GAP: begin
`ifdef MEMS_DAC_LDAC_EN
          // ldac_n went low on GAP entry. It is released after GAP cycle 1.
          if (tmr == TMR_W'(1)) ldac_n <= 1'b1;
`endif
          if (tmr == GAP_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          sclk  <= 1'b1;
          mosi  <= 1'b0;
          sync_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mems_dac_spi.sv
// ----------------------------------------------------------------------------
// tb_mems_dac_spi
//
// Bench for mems_dac_spi with two instances:
//   u_dut0  default parameters (CLK_DIV=2, ROM_LATENCY=1)
//   u_dut1  CLK_DIV=1, ROM_LATENCY=2
// Each instance reads from a synchronous ROM model with the matching latency.
// A negedge monitor rebuilds every SPI frame from the pins:
//   - the bits sampled on sclk falling edges
//   - the fall count and the spacing between falls
//   - the sync_n low length
//   - the sync_n high run before the frame
//   - the busy pulse widths and the busy rise cycles
// Inputs are driven on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_mems_dac_spi;

  localparam int WB = 24;
  localparam int NREC = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start0 = 1'b0;
  logic          start1 = 1'b0;
  logic [3:0]    addr0 = '0;
  logic [3:0]    addr1 = '0;
  logic [WB-1:0] rom [16];
  logic [WB-1:0] rom_q0, rom_p1, rom_q1;
  logic [1:0]    busy_s, sclk_s, mosi_s, sync_s;
`ifdef MEMS_DAC_LDAC_EN
  logic [1:0]    ldac_s;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Synchronous ROM: one register stage for dut0, two for dut1.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rom_q0 <= rom[addr0];
    rom_p1 <= rom[addr1];
    rom_q1 <= rom_p1;
  end

  mems_dac_spi u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .rom_data(rom_q0),
    .busy(busy_s[0]), .sclk(sclk_s[0]), .mosi(mosi_s[0]), .sync_n(sync_s[0])
`ifdef MEMS_DAC_LDAC_EN
    , .ldac_n(ldac_s[0])
`endif
  );

  mems_dac_spi #(.CLK_DIV(1), .ROM_LATENCY(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .rom_data(rom_q1),
    .busy(busy_s[1]), .sclk(sclk_s[1]), .mosi(mosi_s[1]), .sync_n(sync_s[1])
`ifdef MEMS_DAC_LDAC_EN
    , .ldac_n(ldac_s[1])
`endif
  );

  // ---------------------------------------------------------------- monitor
  logic          prev_sclk [2] = '{1'b1, 1'b1};
  logic          prev_sync [2] = '{1'b1, 1'b1};
  logic          prev_mosi [2] = '{1'b0, 1'b0};
  logic          prev_busy [2] = '{1'b0, 1'b0};
  int            busy_run [2] = '{0, 0};
  int            busy_cnt [2] = '{0, 0};
  int            busy_w [2][NREC];
  int            busy_rise [2][NREC];
  logic [WB-1:0] cur_word [2];
  int            cur_falls [2], cur_low [2], cur_minp [2], cur_maxp [2];
  int            cur_gap [2], last_fall [2];
  int            high_run [2] = '{0, 0};
  int            frame_cnt [2] = '{0, 0};
  logic [WB-1:0] fr_word [2][NREC];
  int            fr_falls [2][NREC], fr_low [2][NREC], fr_minp [2][NREC];
  int            fr_maxp [2][NREC], fr_gap [2][NREC];
  int            mosi_bad [2] = '{0, 0};
`ifdef MEMS_DAC_LDAC_EN
  logic          prev_ldac [2] = '{1'b1, 1'b1};
  int            ldac_run [2] = '{0, 0};
  int            ldac_cnt [2] = '{0, 0};
  int            ldac_len [2] = '{0, 0};
  int            ldac_misalign [2] = '{0, 0};
`endif

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      // busy pulses
      if (busy_s[i] && !prev_busy[i]) begin
        busy_run[i] <= 1;
        if (busy_cnt[i] < NREC) busy_rise[i][busy_cnt[i]] <= cyc;
      end else if (busy_s[i]) begin
        busy_run[i] <= busy_run[i] + 1;
      end else if (prev_busy[i]) begin
        if (busy_cnt[i] < NREC) busy_w[i][busy_cnt[i]] <= busy_run[i];
        busy_cnt[i] <= busy_cnt[i] + 1;
      end
      // SPI frames
      if (!sync_s[i]) begin
        if (prev_sync[i]) begin
          cur_word[i]  <= '0;
          cur_falls[i] <= 0;
          cur_low[i]   <= 1;
          cur_minp[i]  <= 1000;
          cur_maxp[i]  <= 0;
          cur_gap[i]   <= high_run[i];
          high_run[i]  <= 0;
        end else begin
          cur_low[i] <= cur_low[i] + 1;
          if (prev_sclk[i] && !sclk_s[i]) begin
            cur_word[i]  <= {cur_word[i][WB-2:0], mosi_s[i]};
            cur_falls[i] <= cur_falls[i] + 1;
            if (cur_falls[i] != 0) begin
              if (cyc - last_fall[i] < cur_minp[i]) cur_minp[i] <= cyc - last_fall[i];
              if (cyc - last_fall[i] > cur_maxp[i]) cur_maxp[i] <= cyc - last_fall[i];
            end
            last_fall[i] <= cyc;
          end
        end
      end else begin
        high_run[i] <= high_run[i] + 1;
        if (!prev_sync[i]) begin
          if (frame_cnt[i] < NREC) begin
            fr_word[i][frame_cnt[i]]  <= cur_word[i];
            fr_falls[i][frame_cnt[i]] <= cur_falls[i];
            fr_low[i][frame_cnt[i]]   <= cur_low[i];
            fr_minp[i][frame_cnt[i]]  <= cur_minp[i];
            fr_maxp[i][frame_cnt[i]]  <= cur_maxp[i];
            fr_gap[i][frame_cnt[i]]   <= cur_gap[i];
          end
          frame_cnt[i] <= frame_cnt[i] + 1;
        end
      end
      if (mosi_s[i] !== prev_mosi[i] && !sclk_s[i]) mosi_bad[i] <= mosi_bad[i] + 1;
`ifdef MEMS_DAC_LDAC_EN
      if (!ldac_s[i] && prev_ldac[i]) begin
        ldac_run[i] <= 1;
        if (!(sync_s[i] && !prev_sync[i])) ldac_misalign[i] <= ldac_misalign[i] + 1;
      end else if (!ldac_s[i]) begin
        ldac_run[i] <= ldac_run[i] + 1;
      end else if (!prev_ldac[i]) begin
        ldac_len[i] <= ldac_run[i];
        ldac_cnt[i] <= ldac_cnt[i] + 1;
      end
      prev_ldac[i] <= ldac_s[i];
`endif
      prev_sclk[i] <= sclk_s[i];
      prev_sync[i] <= sync_s[i];
      prev_mosi[i] <= mosi_s[i];
      prev_busy[i] <= busy_s[i];
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic pulse_start(input int idx, input logic [3:0] a, output int t0);
    @(negedge clk);
    if (idx == 0) begin addr0 = a; start0 = 1'b1; end
    else          begin addr1 = a; start1 = 1'b1; end
    t0 = cyc;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_busy(input int idx, input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      if (busy_cnt[idx] >= target) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++; if (busy_s[i] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d]: got %b expected 0", i, busy_s[i]); end
      checks++; if (sclk_s[i] !== 1'b1) begin failures++; $display("FAIL reset_sclk[%0d]: got %b expected 1", i, sclk_s[i]); end
      checks++; if (mosi_s[i] !== 1'b0) begin failures++; $display("FAIL reset_mosi[%0d]: got %b expected 0", i, mosi_s[i]); end
      checks++; if (sync_s[i] !== 1'b1) begin failures++; $display("FAIL reset_sync_n[%0d]: got %b expected 1", i, sync_s[i]); end
`ifdef MEMS_DAC_LDAC_EN
      checks++; if (ldac_s[i] !== 1'b1) begin failures++; $display("FAIL reset_ldac_n[%0d]: got %b expected 1", i, ldac_s[i]); end
`endif
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_word();
    int t0, bb, fb, mb;
    bit ok;
    bb = busy_cnt[0]; fb = frame_cnt[0]; mb = mosi_bad[0];
`ifdef MEMS_DAC_LDAC_EN
    int lb;
    lb = ldac_cnt[0];
`endif
    pulse_start(0, 4'd0, t0);
    wait_busy(0, bb + 1, 300, ok);
    repeat (4) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout: busy never fell"); end
    checks++; if (busy_rise[0][bb] != t0 + 1) begin failures++; $display("FAIL single_busy_rise: got cycle %0d expected %0d", busy_rise[0][bb], t0 + 1); end
    checks++; if (busy_w[0][bb] != 101) begin failures++; $display("FAIL single_busy_width: got %0d expected 101", busy_w[0][bb]); end
    checks++; if (fr_word[0][fb] !== 24'hA5F00F) begin failures++; $display("FAIL single_word: got %h expected a5f00f", fr_word[0][fb]); end
    checks++; if (fr_falls[0][fb] != 24) begin failures++; $display("FAIL single_falls: got %0d expected 24", fr_falls[0][fb]); end
    checks++; if (fr_low[0][fb] != 96) begin failures++; $display("FAIL single_sync_low: got %0d expected 96", fr_low[0][fb]); end
    checks++; if (fr_minp[0][fb] != 4 || fr_maxp[0][fb] != 4) begin failures++; $display("FAIL single_sclk_period: got %0d..%0d expected 4", fr_minp[0][fb], fr_maxp[0][fb]); end
    checks++; if (mosi_bad[0] != mb) begin failures++; $display("FAIL single_mosi_timing: got %0d changes while sclk low expected 0", mosi_bad[0] - mb); end
`ifdef MEMS_DAC_LDAC_EN
    checks++; if (ldac_cnt[0] != lb + 1) begin failures++; $display("FAIL single_ldac_count: got %0d expected %0d", ldac_cnt[0], lb + 1); end
    checks++; if (ldac_len[0] != 2) begin failures++; $display("FAIL single_ldac_len: got %0d expected 2", ldac_len[0]); end
    checks++; if (ldac_misalign[0] != 0) begin failures++; $display("FAIL single_ldac_align: got %0d misaligned expected 0", ldac_misalign[0]); end
`endif
  endtask

  task automatic test_start_ignored();
    int t0, bb, fb;
    bb = busy_cnt[0]; fb = frame_cnt[0];
    @(negedge clk);
    addr0 = 4'd1; start0 = 1'b1; t0 = cyc;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      start0 = (k == 5 || k == 50);
    end
    start0 = 1'b0;
    repeat (110) @(negedge clk);
    checks++; if (busy_cnt[0] != bb + 1) begin failures++; $display("FAIL ignore_busy_count: got %0d expected %0d", busy_cnt[0] - bb, 1); end
    checks++; if (frame_cnt[0] != fb + 1) begin failures++; $display("FAIL ignore_frame_count: got %0d expected 1", frame_cnt[0] - fb); end
    checks++; if (busy_w[0][bb] != 101) begin failures++; $display("FAIL ignore_busy_width: got %0d expected 101", busy_w[0][bb]); end
    checks++; if (fr_word[0][fb] !== 24'h123456) begin failures++; $display("FAIL ignore_word: got %h expected 123456", fr_word[0][fb]); end
    checks++; if (busy_rise[0][bb] != t0 + 1) begin failures++; $display("FAIL ignore_busy_rise: got %0d expected %0d", busy_rise[0][bb], t0 + 1); end
  endtask

  task automatic test_back_to_back();
    int bb, fb, issued;
    logic s, start_q;
    bit ok;
    bb = busy_cnt[0]; fb = frame_cnt[0];
    issued = 0; start_q = 1'b0; ok = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (busy_cnt[0] >= bb + 5) begin ok = 1'b1; break; end
      s = !busy_s[0] && !start_q && (issued < 5);
      start0 = s;
      if (s) begin addr0 = 4'(8 + issued); issued++; end
      start_q = s;
    end
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout: got %0d words expected 5", busy_cnt[0] - bb); end
    checks++; if (frame_cnt[0] != fb + 5) begin failures++; $display("FAIL b2b_frames: got %0d expected 5", frame_cnt[0] - fb); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (fr_word[0][fb + k] !== rom[8 + k]) begin failures++; $display("FAIL b2b_word[%0d]: got %h expected %h", k, fr_word[0][fb + k], rom[8 + k]); end
      checks++; if (fr_falls[0][fb + k] != 24) begin failures++; $display("FAIL b2b_falls[%0d]: got %0d expected 24", k, fr_falls[0][fb + k]); end
      checks++; if (busy_w[0][bb + k] != 101) begin failures++; $display("FAIL b2b_busy_width[%0d]: got %0d expected 101", k, busy_w[0][bb + k]); end
      if (k > 0) begin
        checks++; if (fr_gap[0][fb + k] < 4) begin failures++; $display("FAIL b2b_sync_gap[%0d]: got %0d expected >=4", k, fr_gap[0][fb + k]); end
        checks++; if (busy_rise[0][bb + k] - busy_rise[0][bb + k - 1] != 102) begin failures++; $display("FAIL b2b_spacing[%0d]: got %0d expected 102", k, busy_rise[0][bb + k] - busy_rise[0][bb + k - 1]); end
      end
    end
  endtask

  task automatic test_reset_abort();
    int t0, t1, bb, fb;
    bit ok;
`ifdef MEMS_DAC_LDAC_EN
    int lb;
    lb = ldac_cnt[0];
`endif
    @(negedge clk);
    addr0 = 4'd3; start0 = 1'b1; t0 = cyc;
    for (int k = 1; k <= 56; k++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    // Cycle t0+56 is the low phase of bit 10, which is a 1 in 0x5a0ff0.
    checks++; if (sync_s[0] !== 1'b0 || sclk_s[0] !== 1'b0 || mosi_s[0] !== 1'b1) begin
      failures++; $display("FAIL abort_pre: got sync_n=%b sclk=%b mosi=%b expected 0 0 1", sync_s[0], sclk_s[0], mosi_s[0]); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy_s[0] !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy_s[0]); end
    checks++; if (sync_s[0] !== 1'b1) begin failures++; $display("FAIL abort_sync_n: got %b expected 1", sync_s[0]); end
    checks++; if (sclk_s[0] !== 1'b1) begin failures++; $display("FAIL abort_sclk: got %b expected 1", sclk_s[0]); end
    checks++; if (mosi_s[0] !== 1'b0) begin failures++; $display("FAIL abort_mosi: got %b expected 0", mosi_s[0]); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
`ifdef MEMS_DAC_LDAC_EN
    checks++; if (ldac_cnt[0] != lb) begin failures++; $display("FAIL abort_ldac: got %0d pulses expected 0", ldac_cnt[0] - lb); end
`endif
    bb = busy_cnt[0]; fb = frame_cnt[0];
    pulse_start(0, 4'd4, t1);
    wait_busy(0, bb + 1, 300, ok);
    repeat (4) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL after_abort_timeout: busy never fell"); end
    checks++; if (fr_word[0][fb] !== 24'h3C3C3C) begin failures++; $display("FAIL after_abort_word: got %h expected 3c3c3c", fr_word[0][fb]); end
    checks++; if (fr_falls[0][fb] != 24) begin failures++; $display("FAIL after_abort_falls: got %0d expected 24", fr_falls[0][fb]); end
    checks++; if (busy_w[0][bb] != 101) begin failures++; $display("FAIL after_abort_busy_width: got %0d expected 101", busy_w[0][bb]); end
`ifdef MEMS_DAC_LDAC_EN
    checks++; if (ldac_cnt[0] != lb + 1) begin failures++; $display("FAIL after_abort_ldac: got %0d pulses expected 1", ldac_cnt[0] - lb); end
`endif
  endtask

  task automatic test_div1_lat2();
    int t0, bb, fb, mb;
    bit ok;
    bb = busy_cnt[1]; fb = frame_cnt[1]; mb = mosi_bad[1];
    pulse_start(1, 4'd5, t0);
    wait_busy(1, bb + 1, 200, ok);
    repeat (4) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL div1_timeout: busy never fell"); end
    checks++; if (busy_rise[1][bb] != t0 + 1) begin failures++; $display("FAIL div1_busy_rise: got %0d expected %0d", busy_rise[1][bb], t0 + 1); end
    checks++; if (busy_w[1][bb] != 54) begin failures++; $display("FAIL div1_busy_width: got %0d expected 54", busy_w[1][bb]); end
    checks++; if (fr_word[1][fb] !== 24'h0F1E2D) begin failures++; $display("FAIL div1_word: got %h expected 0f1e2d", fr_word[1][fb]); end
    checks++; if (fr_falls[1][fb] != 24) begin failures++; $display("FAIL div1_falls: got %0d expected 24", fr_falls[1][fb]); end
    checks++; if (fr_low[1][fb] != 48) begin failures++; $display("FAIL div1_sync_low: got %0d expected 48", fr_low[1][fb]); end
    checks++; if (fr_minp[1][fb] != 2 || fr_maxp[1][fb] != 2) begin failures++; $display("FAIL div1_sclk_period: got %0d..%0d expected 2", fr_minp[1][fb], fr_maxp[1][fb]); end
    checks++; if (mosi_bad[1] != mb) begin failures++; $display("FAIL div1_mosi_timing: got %0d changes while sclk low expected 0", mosi_bad[1] - mb); end
`ifdef MEMS_DAC_LDAC_EN
    checks++; if (ldac_len[1] != 2 || ldac_misalign[1] != 0) begin failures++; $display("FAIL div1_ldac: got len %0d misaligned %0d expected 2 0", ldac_len[1], ldac_misalign[1]); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = '0;
    rom[0]  = 24'hA5F00F;
    rom[1]  = 24'h123456;
    rom[3]  = 24'h5A0FF0;
    rom[4]  = 24'h3C3C3C;
    rom[5]  = 24'h0F1E2D;
    rom[8]  = 24'h800001;
    rom[9]  = 24'h7FFFFE;
    rom[10] = 24'hC3A55A;
    rom[11] = 24'h000000;
    rom[12] = 24'hFEDCBA;

    test_reset();
    test_single_word();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_div1_lat2();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
